// File: rtl/piso_arb_ctrl_pkg.sv
// Shared types and constants for the two-requester PISO arbiter/serializer.
// PARITY state is present only when PISO_ARB_CTRL_PAR_BIT_EN is defined.
package piso_pkg;

  localparam int PISO_N = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT
`ifdef PISO_ARB_CTRL_PAR_BIT_EN
    ,
    PARITY
`endif
  } state_e;

  typedef enum logic {
    CTRL_LOAD  = 1'b0,
    CTRL_SHIFT = 1'b1
  } ctrl_e;

endpackage

// File: rtl/piso_arb_ctrl_if.sv
// Request/serial bus between two requesters and the PISO arbiter.
// master = requester side, slave = piso_arb_ctrl side.
interface piso_arb_ctrl_if #(
  parameter int N = piso_pkg::PISO_N
);
  logic [1:0]   req_valid;
  logic [N-1:0] req_data0;
  logic [N-1:0] req_data1;
  logic [1:0]   req_ready;
  logic         ser_out;
  logic         ser_valid;
  logic         frame_start;
  logic         frame_done;
  logic         grant_id;

  modport master (
    output req_valid, req_data0, req_data1,
    input  req_ready, ser_out, ser_valid, frame_start, frame_done, grant_id
  );

  modport slave (
    input  req_valid, req_data0, req_data1,
    output req_ready, ser_out, ser_valid, frame_start, frame_done, grant_id
  );
endinterface

// File: rtl/piso_arb_ctrl_core.sv
// Load/shift register: loads a parallel word, then shifts left presenting the MSB.
module piso_core
  import piso_pkg::*;
#(
  parameter int N = PISO_N
) (
  input  logic         clk,
  input  logic         rst,
  input  ctrl_e        control,
  input  logic [N-1:0] in,
  output logic         out
);

  logic [N-1:0] shreg_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
    end else if (control == CTRL_LOAD) begin
      shreg_q <= in;
    end else begin
      shreg_q <= {shreg_q[N-2:0], 1'b0};
    end
  end

  assign out = shreg_q[N-1];

endmodule

// File: rtl/piso_arb_ctrl.sv
// Round-robin arbiter for two parallel requesters feeding an MSB-first serializer.
// Define PISO_ARB_CTRL_PAR_BIT_EN to append an even-parity bit to every frame.
module piso_arb_ctrl
  import piso_pkg::*;
#(
  parameter int N = PISO_N
) (
  input  logic           clk,
  input  logic           rst,
  piso_arb_ctrl_if.slave bus
);

  localparam int CW = $clog2(N);

  state_e        state_q, state_d;
  logic [CW-1:0] bitCnt_q, bitCnt_d;
  logic          lastGrant_q, lastGrant_d;
  logic          gnt;
  logic          handshake;
  logic [N-1:0]  loadWord;
  logic [N-1:0]  coreIn;
  ctrl_e         coreCtrl;
  logic          coreOut;
`ifdef PISO_ARB_CTRL_PAR_BIT_EN
  logic          parity_q;
`endif

  // A lone requester wins; on a tie the one not served last goes next.
  always_comb begin
    gnt = ~lastGrant_q;
    if (bus.req_valid == 2'b01) begin
      gnt = 1'b0;
    end else if (bus.req_valid == 2'b10) begin
      gnt = 1'b1;
    end
  end

  assign handshake = (state_q == IDLE) && (|bus.req_valid) && !rst;
  assign loadWord  = gnt ? bus.req_data1 : bus.req_data0;
  assign coreIn    = handshake ? loadWord : '0;

  always_comb begin
    state_d         = state_q;
    bitCnt_d        = bitCnt_q;
    lastGrant_d     = lastGrant_q;
    coreCtrl        = CTRL_LOAD;
    bus.req_ready   = 2'b00;
    bus.ser_out     = 1'b0;
    bus.ser_valid   = 1'b0;
    bus.frame_start = 1'b0;
    bus.frame_done  = 1'b0;
    bus.grant_id    = 1'b0;
    case (state_q)
      IDLE: begin
        if (handshake) begin
          bus.req_ready[gnt] = 1'b1;
          bus.grant_id       = gnt;
          lastGrant_d        = gnt;
          bitCnt_d           = CW'(N - 1);
          state_d            = SHIFT;
        end
      end
      SHIFT: begin
        coreCtrl        = CTRL_SHIFT;
        bus.ser_valid   = 1'b1;
        bus.ser_out     = coreOut;
        bus.grant_id    = lastGrant_q;
        bus.frame_start = (bitCnt_q == CW'(N - 1));
        bitCnt_d        = bitCnt_q - CW'(1);
        if (bitCnt_q == '0) begin
`ifdef PISO_ARB_CTRL_PAR_BIT_EN
          state_d = PARITY;
`else
          bus.frame_done = 1'b1;
          state_d        = IDLE;
`endif
        end
      end
`ifdef PISO_ARB_CTRL_PAR_BIT_EN
      PARITY: begin
        coreCtrl       = CTRL_SHIFT;
        bus.ser_valid  = 1'b1;
        bus.ser_out    = parity_q;
        bus.grant_id   = lastGrant_q;
        bus.frame_done = 1'b1;
        state_d        = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bitCnt_q    <= '0;
      lastGrant_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      bitCnt_q    <= bitCnt_d;
      lastGrant_q <= lastGrant_d;
    end
  end

`ifdef PISO_ARB_CTRL_PAR_BIT_EN
  // Parity is captured with the word so later data changes cannot disturb it.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else if (handshake) begin
      parity_q <= ^loadWord;
    end
  end
`endif

  piso_core #(.N(N)) u_core (
    .clk     (clk),
    .rst     (rst),
    .control (coreCtrl),
    .in      (coreIn),
    .out     (coreOut)
  );

endmodule

// File: doc/piso_arb_ctrl.md
PISO_ARB_CTRL -- requirements
Module: piso_arb_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the parallel word width in bits, with N >= 2.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port req_valid, input, 2 bits: per-requester word-available flags.
REQ-005 The block SHALL have ports req_data0 and req_data1, inputs, N bits each: the parallel words from requesters 0 and 1.
REQ-006 The block SHALL have port req_ready, output, 2 bits: a one-hot acceptance strobe.
REQ-007 The block SHALL have port ser_out, output, 1 bit: the serial data bit.
REQ-008 The block SHALL have port ser_valid, output, 1 bit: high while ser_out carries a frame bit.
REQ-009 The block SHALL have ports frame_start and frame_done, outputs, 1 bit each: high on the first and last bit of a frame.
REQ-010 The block SHALL have port grant_id, output, 1 bit: the requester owning the current frame.

Function
REQ-011 The FSM SHALL have states IDLE, SHIFT and PARITY; the PARITY state exists only with PAR_BIT_EN.
REQ-012 In IDLE with any req_valid bit high, the block SHALL grant exactly one requester and pulse its req_ready bit for that single cycle.
REQ-013 A transfer SHALL complete only on a cycle where req_valid[g] and req_ready[g] are both high; the block SHALL load the granted data into the shift register in that cycle (control = load) and move to SHIFT.
REQ-014 Arbitration SHALL be round-robin: a lone valid requester wins; when both are valid, the requester not granted last wins; the last-grant register resets to 1, so requester 0 wins the first tie.
REQ-015 In SHIFT, the block SHALL present bits MSB first, one per cycle, for N cycles, and SHALL hold ser_valid high for those cycles.
REQ-016 The first serial bit SHALL appear the cycle after the handshake.
REQ-017 frame_start SHALL be high on bit N-1 only.
REQ-018 grant_id SHALL be stable from the handshake cycle until the frame ends.
REQ-019 Without parity, frame_done SHALL be high on bit 0 and the FSM SHALL return to IDLE.
REQ-020 req_ready SHALL be 0 outside IDLE; requesters hold data and valid until accepted, and no request is lost.
REQ-021 The back-to-back gap SHALL be exactly one idle cycle between frames, the handshake cycle, with ser_valid low in that cycle.
REQ-022 When ser_valid is low, ser_out SHALL be 0.
REQ-023 Changes to req_data* after acceptance SHALL NOT affect the frame in flight.

Reset
REQ-024 When rst is high at a clock edge, the FSM SHALL go to IDLE and the shift register, bit counter and all outputs SHALL clear to 0, with last-grant set to 1.
REQ-025 Reset asserted mid-frame SHALL abort the frame, with no frame_done pulse.
REQ-026 The first grant SHALL be possible on the first cycle with rst low.

Configuration
REQ-027 With macro PISO_ARB_CTRL_PAR_BIT_EN defined, the block SHALL append one even-parity bit (XOR of the N data bits) after bit 0.
REQ-028 With the macro defined, ser_valid SHALL stay high for the parity bit, frame_done SHALL move to the parity bit, and the frame SHALL be N+1 bits long.
REQ-029 With the macro undefined, the PARITY state and its logic SHALL be absent and frames SHALL be N bits.

Structure
REQ-030 A shared package piso_pkg SHALL hold the FSM state enum, the default width constant PISO_N = 8, and the load/shift control encoding (0 = load, 1 = shift).
REQ-031 The shift register SHALL be a sub-module piso_core with ports clk, rst, control, in and out, driven by the FSM.

Verification
REQ-032 Reset, then req_valid = 01 with req_data0 = 8'hDD -> req_ready = 01 for one cycle; ser_out = 1,1,0,1,1,1,0,1 over the next 8 cycles; frame_start on the first bit; frame_done on the eighth.
REQ-033 Both requesters valid continuously, with req_data0 = 8'h2E and req_data1 = 8'h0A -> grants alternate 0,1,0,1; one-cycle gaps between frames; grant_id matches each frame.
REQ-034 Change req_data0 from 8'h80 to 8'hFF mid-frame -> the serial stream is still 1,0,0,0,0,0,0,0.
REQ-035 Assert rst on the fourth bit of a frame -> the next cycle shows all outputs 0 and no frame_done; the pending request is re-granted after rst falls.
REQ-036 With PISO_ARB_CTRL_PAR_BIT_EN and data 8'hDD -> a ninth bit of 0 appears; frame_done on bit 9; with data 8'h80 the ninth bit is 1.
